ahb_ai_ctrl_slave: RTL

- Parametrised AHB-Lite slave that fronts the transformer engine.
- Provides a control/status register bank and a streaming weight-memory write window.
- Captures the engine result into a read-back buffer and raises an interrupt on completion.
- Adds proper address/data-phase pipelining, an ERROR response and a busy-cycle counter.
- Sits between the system AHB fabric and transformer_top; all on one clock.

---
 rtl/ahb_ai_pkg.sv | 32 +++
 rtl/ahb_lite_slave_pipe.sv | 68 ++++++
 rtl/ahb_ai_ctrl_slave.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ahb_ai_pkg.sv
// Shared AHB encodings, register map and FSM typedef for the transformer-engine AHB slave.
package ahb_ai_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam int unsigned REG_CTRL   = 32'h000;
  localparam int unsigned REG_STATUS = 32'h004;
  localparam int unsigned REG_CYCLES = 32'h008;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLR    = 2;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fsm_state_e;

  function automatic int unsigned res_words(input int unsigned idim, input int unsigned width);
    return (idim * width) / 32;
  endfunction

endpackage

// File: rtl/ahb_lite_slave_pipe.sv
// AHB-Lite address/data-phase pipeline: captures the address phase, sequences the
// two-cycle ERROR response and hands qualified wr/rd strobes to the register bank.
module ahb_lite_slave_pipe
  import ahb_ai_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              hsel_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [1:0]        htrans_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic              hready_i,
  input  logic              ext_err_i,
  output logic              wr_req_o,
  output logic              wr_o,
  output logic              rd_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              hreadyout_o,
  output logic              hresp_o
);

  logic              valid_q;
  logic              write_q;
  logic              err2_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;

  logic accept_c;
  logic fmt_err_c;
  logic err_c;

  assign accept_c  = hsel_i & hready_i &
                     ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));
  assign fmt_err_c = (size_q != HSIZE_WORD) | (addr_q[1:0] != 2'b00);
  // ERROR first cycle is decided in the data phase so the bank can veto on hwdata
  assign err_c     = valid_q & (fmt_err_c | ext_err_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      err2_q  <= 1'b0;
      size_q  <= HSIZE_WORD;
      addr_q  <= '0;
    end else begin
      valid_q <= accept_c;
      err2_q  <= err_c;
      if (accept_c) begin
        addr_q  <= haddr_i;
        write_q <= hwrite_i;
        size_q  <= hsize_i;
      end
    end
  end

  assign wr_req_o    = valid_q & write_q;
  assign wr_o        = valid_q & write_q & ~err_c;
  assign rd_o        = valid_q & ~write_q & ~err_c;
  assign err_o       = err_c;
  assign addr_o      = addr_q;
  assign hreadyout_o = ~err_c;
  assign hresp_o     = err_c | err2_q;

endmodule

// File: rtl/ahb_ai_ctrl_slave.sv
// AHB-Lite control/status slave for the transformer engine: register bank, weight
// write window, result read-back buffer, busy-cycle counter and completion interrupt.
module ahb_ai_ctrl_slave
  import ahb_ai_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned IDIM       = 32,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned WMEM_DEPTH = 512,
  parameter int unsigned WMEM_BASE  = 32'h0400,
  parameter int unsigned RES_BASE   = 32'h0C00
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hsel,
  input  logic [ADDR_W-1:0]             haddr,
  input  logic [1:0]                    htrans,
  input  logic                          hwrite,
  input  logic [2:0]                    hsize,
  input  logic [31:0]                   hwdata,
  input  logic                          hready,
  output logic [31:0]                   hrdata,
  output logic                          hreadyout,
  output logic                          hresp,
  output logic                          eng_start,
  input  logic                          eng_done,
  input  logic [IDIM*WIDTH-1:0]         eng_result,
  output logic                          wmem_we,
  output logic [$clog2(WMEM_DEPTH)-1:0] wmem_addr,
  output logic [31:0]                   wmem_wdata,
  output logic                          irq
);

  localparam int unsigned RES_W     = IDIM * WIDTH;
  localparam int unsigned RES_WORDS = res_words(IDIM, WIDTH);
  localparam int unsigned WA_W      = $clog2(WMEM_DEPTH);
  localparam int unsigned RW_W      = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
  localparam int unsigned WMEM_END  = WMEM_BASE + 4 * WMEM_DEPTH;
  localparam int unsigned RES_END   = RES_BASE + 4 * RES_WORDS;

  fsm_state_e       state_q;
  logic             irq_en_q;
  logic             done_q;
  logic             err_q;
  logic             eng_start_q;
  logic             irq_q;
  logic [31:0]      cycles_q;
  logic [RES_W-1:0] result_q;

  logic [ADDR_W-1:0] addr;
  logic              wr_req;
  logic              wr;
  logic              rd;
  logic              err;

  logic [31:0]     addr32_c;
  logic [31:0]     rdata_c;
  logic [RW_W-1:0] rword_c;
  logic [31:0]     res_word_c [RES_WORDS];
  logic            in_wmem_c;
  logic            in_res_c;
  logic            busy_c;
  logic            busy_eff_c;
  logic            ext_err_c;
  logic            ctrl_wr_c;
  logic            start_c;
  logic            clr_c;
  logic            w1c_c;

  ahb_lite_slave_pipe #(
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk_i       (clk),
    .reset_i     (reset),
    .hsel_i      (hsel),
    .haddr_i     (haddr),
    .htrans_i    (htrans),
    .hwrite_i    (hwrite),
    .hsize_i     (hsize),
    .hready_i    (hready),
    .ext_err_i   (ext_err_c),
    .wr_req_o    (wr_req),
    .wr_o        (wr),
    .rd_o        (rd),
    .err_o       (err),
    .addr_o      (addr),
    .hreadyout_o (hreadyout),
    .hresp_o     (hresp)
  );

  for (genvar k = 0; k < RES_WORDS; k++) begin : g_res
    assign res_word_c[k] = result_q[32*k +: 32];
  end

  assign addr32_c  = 32'(addr);
  assign in_wmem_c = (addr32_c >= WMEM_BASE) && (addr32_c < WMEM_END);
  assign in_res_c  = (addr32_c >= RES_BASE) && (addr32_c < RES_END);
  assign rword_c   = RW_W'((addr32_c - RES_BASE) >> 2);

  // A completing run in the same cycle frees the engine for a new START or weight write
  assign busy_c     = (state_q == S_RUN);
  assign busy_eff_c = busy_c & ~eng_done;
  assign ext_err_c  = wr_req & busy_eff_c &
                      (in_wmem_c | ((addr32_c == REG_CTRL) & hwdata[CTRL_START]));

  assign ctrl_wr_c = wr & (addr32_c == REG_CTRL);
  assign start_c   = ctrl_wr_c & hwdata[CTRL_START];
  assign clr_c     = ctrl_wr_c & hwdata[CTRL_CLR];
  assign w1c_c     = wr & (addr32_c == REG_STATUS) & hwdata[STAT_DONE];

  // Zero-wait-state read mux driven from the registered address
  always_comb begin
    rdata_c = '0;
    if (rd) begin
      if (addr32_c == REG_CTRL) begin
        rdata_c[CTRL_IRQ_EN] = irq_en_q;
      end else if (addr32_c == REG_STATUS) begin
        rdata_c[STAT_BUSY] = busy_c;
        rdata_c[STAT_DONE] = done_q;
        rdata_c[STAT_ERR]  = err_q;
      end else if (addr32_c == REG_CYCLES) begin
        rdata_c = cycles_q;
      end else if (in_res_c) begin
        rdata_c = res_word_c[rword_c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
      irq_q       <= 1'b0;
      cycles_q    <= '0;
      result_q    <= '0;
    end else begin
      eng_start_q <= start_c;
      irq_q       <= done_q & irq_en_q;
      if (eng_done) begin
        result_q <= eng_result;
      end
      if (ctrl_wr_c) begin
        irq_en_q <= hwdata[CTRL_IRQ_EN];
      end
      // Completion set beats a same-cycle clear
      if (eng_done) begin
        done_q <= 1'b1;
      end else if (clr_c | w1c_c) begin
        done_q <= 1'b0;
      end
      if (err) begin
        err_q <= 1'b1;
      end else if (clr_c) begin
        err_q <= 1'b0;
      end
      if (start_c | clr_c) begin
        cycles_q <= '0;
      end else if (busy_c && (cycles_q != '1)) begin
        cycles_q <= cycles_q + 32'd1;
      end
      case (state_q)
        S_IDLE:  if (start_c) state_q <= S_RUN;
        S_RUN:   if (!start_c && eng_done) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hrdata     = rdata_c;
  assign eng_start  = eng_start_q;
  assign irq        = irq_q;
  assign wmem_we    = wr & in_wmem_c;
  assign wmem_addr  = WA_W'((addr32_c - WMEM_BASE) >> 2);
  assign wmem_wdata = hwdata;

endmodule
